// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// Direction and mode encodings, plus the preset clamp used on load.
// Pure definitions; no state, no timing.
package mod_counter_pkg;

  localparam bit DIR_UP    = 1'b1;
  localparam bit DIR_DOWN  = 1'b0;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // Out-of-range presets land on the top count rather than being truncated.
  // 33-bit operands cover every legal WIDTH, including MODULUS = 2**32.
  function automatic logic [32:0] clamp_preset(input logic [32:0] value,
                                               input logic [32:0] modulus);
    clamp_preset = (value < modulus) ? value : (modulus - 33'd1);
  endfunction

endpackage

// File: rtl/mod_counter_step.sv
// Next-count and terminal-event calculation for the modulo up/down counter.
// Purely combinational, zero latency.
// No flow control; the caller decides whether to apply the result.
module mod_counter_step
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter bit     SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] a,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             term
);

  // One spare bit so MODULUS = 2**WIDTH still has an exact MODULUS-1.
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] sum;
  logic           unused_sum_msb;

  // Step one count in the requested direction, handling the range ends.
  always_comb begin
    a_ext = {1'b0, a};
    sum   = a_ext;
    term  = 1'b0;
    if (up == DIR_UP) begin
      term = (a_ext == MAX);
      if (!term)                       sum = a_ext + ONE;
      else if (SATURATE == MODE_WRAP)  sum = '0;
    end else begin
      term = (a_ext == '0);
      if (!term)                       sum = a_ext - ONE;
      else if (SATURATE == MODE_WRAP)  sum = MAX;
    end
  end

  assign nxt            = sum[WIDTH-1:0];
  assign unused_sum_msb = sum[WIDTH];

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with preset, wrap pulse and optional sticky overflow.
// One cycle: a, wrap and ovf are registered and reflect the previous edge's inputs.
// No backpressure; en gates counting. Sticky ovf built only with MOD_UPDOWN_COUNTER_STICKY_EN.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter bit     SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             pr,
  input  logic [WIDTH-1:0] n,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] a,
  output logic             wrap,
  output logic             ovf
);

  generate
    if (WIDTH < 2 || WIDTH > 32)
      $error("mod_updown_counter: WIDTH must be 2..32");
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH))
      $error("mod_updown_counter: MODULUS must be 2..2**WIDTH");
  endgenerate

  localparam logic [32:0] MOD33 = 33'(MODULUS);

  logic [WIDTH-1:0]  nxt;
  logic              term;
  logic              evt;
  logic [32:0]       preset_full;
  logic [WIDTH-1:0]  preset;
  logic [32-WIDTH:0] unused_preset_hi;

  mod_counter_step #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_step (
    .a    (a),
    .up   (up),
    .nxt  (nxt),
    .term (term)
  );

  assign preset_full      = clamp_preset(33'(n), MOD33);
  assign preset           = preset_full[WIDTH-1:0];
  assign unused_preset_hi = preset_full[32:WIDTH];

  // A terminal event only counts when the counter is actually stepping.
  assign evt = en & ~pr & term;

  // Count register and terminal pulse: preset beats enable beats hold.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a    <= '0;
      wrap <= 1'b0;
    end else if (pr) begin
      a    <= preset;
      wrap <= 1'b0;
    end else if (en) begin
      a    <= nxt;
      wrap <= term;
    end else begin
      wrap <= 1'b0;
    end
  end

`ifdef MOD_UPDOWN_COUNTER_STICKY_EN
  // Sticky overflow: a new event wins over a same-edge clear request.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)          ovf <= 1'b0;
    else if (evt)     ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`else
  logic unused_ovf_inputs;

  assign ovf               = 1'b0;
  assign unused_ovf_inputs = ovf_clr ^ evt;
`endif

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: count, load and output width in bits; SHALL be 2..32.
REQ-002 Parameter MODULUS, default 256: count range 0..MODULUS-1; SHALL be 2..2**WIDTH, checked at elaboration.
REQ-003 Parameter SATURATE, default 0: 0 = wrap mode, 1 = saturate mode.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  count enable.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 pr  input  1  synchronous preset; loads n.
REQ-009 n  input  WIDTH  preset value.
REQ-010 a  output  WIDTH  registered count value.
REQ-011 wrap  output  1  registered one-cycle terminal-event pulse.
REQ-012 ovf_clr  input  1  clears the sticky overflow flag.
REQ-013 ovf  output  1  registered sticky overflow flag.

Function
REQ-014 Per-edge priority SHALL be: pr, then en, then hold.
REQ-015 pr=1: a SHALL load n when n < MODULUS, else MODULUS-1; a held pr reloads every edge; en and up are ignored.
REQ-016 pr=0, en=1, up=1, a < MODULUS-1: a SHALL become a+1.
REQ-017 pr=0, en=1, up=0, a > 0: a SHALL become a-1.
REQ-018 Terminal event: en=1, pr=0, and either up=1 with a==MODULUS-1 or up=0 with a==0.
REQ-019 On a terminal event with SATURATE=0, a SHALL wrap to 0 (up) or MODULUS-1 (down).
REQ-020 On a terminal event with SATURATE=1, a SHALL hold its value.
REQ-021 wrap SHALL be 1 for exactly the cycle after each terminal event and 0 otherwise.
REQ-022 wrap SHALL re-pulse on every edge while a terminal event persists (saturate mode included).
REQ-023 pr=0, en=0: a and wrap SHALL hold, and wrap SHALL be 0.
REQ-024 Arithmetic SHALL use WIDTH+1 bits internally, so MODULUS = 2**WIDTH wraps without truncation error.
REQ-025 Changing up mid-count SHALL take effect on the next edge with no glitch cycle.

Reset
REQ-026 While clr=1: a=0, wrap=0, ovf=0 immediately, independent of clk.
REQ-027 clr SHALL override pr, en and ovf_clr.
REQ-028 After clr deasserts, the first rising edge SHALL operate normally.
REQ-029 clr asserted mid-count SHALL discard any pending wrap pulse.

Configuration
REQ-030 Macro MOD_UPDOWN_COUNTER_STICKY_EN defined: ovf SHALL set on the edge of any terminal event and stay set until an edge with ovf_clr=1.
REQ-031 If a terminal event and ovf_clr=1 occur on the same edge, set SHALL win.
REQ-032 Macro MOD_UPDOWN_COUNTER_STICKY_EN undefined: ovf SHALL be tied to 0, ovf_clr ignored, no flag register built; all other behaviour identical.

Structure
REQ-033 Package mod_counter_pkg SHALL hold: the direction constants DIR_UP/DIR_DOWN; the mode constants MODE_WRAP/MODE_SAT; and the function that clamps a preset value to MODULUS-1.
REQ-034 Sub-module mod_counter_step (combinational) SHALL compute next value and terminal flag from a, up, MODULUS and SATURATE; the top holds all registers.

Verification
REQ-035 WIDTH=4, MODULUS=10, SATURATE=0, up=1, en=1 from a=0 for 10 edges -> a goes 1..9 then 0; wrap high only in the cycle after 9->0.
REQ-036 Same config, up=0 from a=0 -> a=9 next edge; wrap pulse one cycle; a then counts 8, 7, ...
REQ-037 SATURATE=1, MODULUS=10, up=1 from a=8 for 4 edges -> a=9, 9, 9, 9; wrap high on 3 consecutive cycles.
REQ-038 Preset: pr=1, n=7, then pr=1, n=15 with MODULUS=10 -> a=7, then a=9; en=1 concurrently has no effect.
REQ-039 clr pulse mid-count at a=5, between clock edges -> a=0, wrap=0, ovf=0 without waiting for clk; next edge counts to 1.
REQ-040 With MOD_UPDOWN_COUNTER_STICKY_EN: terminal event with ovf_clr=1 on the same edge -> ovf=1; next edge with ovf_clr=1 and no event -> ovf=0.
REQ-041 Without the macro: repeat REQ-040 stimulus -> ovf stays 0.
